// File: rtl/fpro_bridge_ctrl.sv
// Registered single-outstanding-transaction bridge from the MCS I/O bus to the FPRO bus.
// Define FPRO_BRIDGE_UNMAPPED_RESP_EN to answer unmapped accesses and flag them in err_unmapped.
module fpro_bridge_ctrl #(
  parameter logic [31:0] BRG_BASE = 32'hC000_0000,
  parameter int          NUM_CS   = 2,
  parameter int          ADDR_W   = 21,
  parameter int          RD_LAT   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              io_addr_strobe,
  input  logic              io_read_strobe,
  input  logic              io_write_strobe,
  input  logic [3:0]        io_byte_enable,
  input  logic [31:0]       io_address,
  input  logic [31:0]       io_write_data,
  output logic [31:0]       io_read_data,
  output logic              io_ready,
  output logic [NUM_CS-1:0] fp_cs,
  output logic              fp_wr,
  output logic              fp_rd,
  output logic [ADDR_W-1:0] fp_addr,
  output logic [3:0]        fp_be,
  output logic [31:0]       fp_wr_data,
  input  logic [31:0]       fp_rd_data,
  input  logic              err_clr,
  output logic              err_unmapped
);
  localparam int         CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RDWAIT, RESP} state_t;

  state_t            state;
  logic              is_wr;
  logic [3:0]        lat_cnt;
  logic              start;
  logic              hit;
  logic [CS_W-1:0]   cs_idx;
  logic [NUM_CS-1:0] cs_onehot;
  logic              unused_bits;

  assign start  = (state == IDLE) && io_addr_strobe && (io_read_strobe || io_write_strobe);
  assign hit    = (io_address[31:24] == BRG_BASE[31:24]);
  // A single region takes every hit; otherwise the top bits below the base byte pick the region.
  assign cs_idx = (NUM_CS > 1) ? io_address[23 -: CS_W] : '0;

  always_comb begin
    cs_onehot = '0;
    for (int i = 0; i < NUM_CS; i++) cs_onehot[i] = (cs_idx == CS_W'(i));
  end

  assign unused_bits = ^{io_address, err_clr};

`ifndef FPRO_BRIDGE_UNMAPPED_RESP_EN
  assign err_unmapped = 1'b0;
`endif

  // NOTE: every register below is written with <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      is_wr        <= 1'b0;
      lat_cnt      <= 4'd0;
      io_read_data <= '0;
      io_ready     <= 1'b0;
      fp_cs        <= '0;
      fp_wr        <= 1'b0;
      fp_rd        <= 1'b0;
      fp_addr      <= '0;
      fp_be        <= '0;
      fp_wr_data   <= '0;
`ifdef FPRO_BRIDGE_UNMAPPED_RESP_EN
      err_unmapped <= 1'b0;
`endif
    end else begin
      io_ready <= 1'b0;
      fp_wr    <= 1'b0;
      fp_rd    <= 1'b0;
`ifdef FPRO_BRIDGE_UNMAPPED_RESP_EN
      if (err_clr) err_unmapped <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            is_wr <= io_write_strobe;
            if (hit) begin
              state      <= ACCESS;
              fp_cs      <= cs_onehot;
              fp_addr    <= io_address[ADDR_W+1:2];
              fp_be      <= io_byte_enable;
              fp_wr_data <= io_write_data;
              fp_wr      <= io_write_strobe;
              fp_rd      <= !io_write_strobe;
            end
`ifdef FPRO_BRIDGE_UNMAPPED_RESP_EN
            else begin
              // Set is written after the clear above, so a simultaneous err_clr loses.
              state        <= RESP;
              io_ready     <= 1'b1;
              err_unmapped <= 1'b1;
              if (!io_write_strobe) io_read_data <= '0;
            end
`endif
          end
        end
        ACCESS: begin
          if (is_wr) begin
            state      <= RESP;
            io_ready   <= 1'b1;
            fp_cs      <= '0;
            fp_addr    <= '0;
            fp_be      <= '0;
            fp_wr_data <= '0;
          end else begin
            state   <= RDWAIT;
            lat_cnt <= LAT_INIT;
          end
        end
        RDWAIT: begin
          if (lat_cnt == 4'd0) begin
            state        <= RESP;
            io_ready     <= 1'b1;
            io_read_data <= fp_rd_data;
            fp_cs        <= '0;
            fp_addr      <= '0;
            fp_be        <= '0;
            fp_wr_data   <= '0;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/fpro_bridge_ctrl.md
# fpro_bridge_ctrl

Registered, FSM-sequenced bridge between the MicroBlaze MCS I/O bus and the FPRO bus. It replaces the combinational bridge with a single-outstanding-transaction engine. Features: a parametrised number of one-hot chip-select regions, a configurable FPRO read latency, byte-enable pass-through, and an `io_ready` handshake back to the processor. It sits between the MCS I/O port and the FPRO video/MMIO subsystems.

## Interface
- `BRG_BASE`, 32'hC000_0000 — byte base address; only bits [31:24] are decoded.
- `NUM_CS`, 2 — number of FPRO chip-select regions; power of 2, 1..16. Index 0 is MMIO, index 1 is video.
- `ADDR_W`, 21 — FPRO word-address width. Constraint: ADDR_W + 2 + log2(NUM_CS) ≤ 24.
- `RD_LAT`, 1 — FPRO cycles from the `fp_rd` cycle to valid `fp_rd_data`; range 1..15.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-high reset.
- `io_addr_strobe` in 1 — MCS transaction start, one-cycle pulse.
- `io_read_strobe` in 1 — read request; qualified by `io_addr_strobe`.
- `io_write_strobe` in 1 — write request; qualified by `io_addr_strobe`.
- `io_byte_enable` in 4 — byte lanes.
- `io_address` in 32 — byte address.
- `io_write_data` in 32 — write data.
- `io_read_data` out 32 — registered read data.
- `io_ready` out 1 — one-cycle transaction-complete pulse.
- `fp_cs` out NUM_CS — one-hot region select.
- `fp_wr` out 1 — one-cycle write pulse.
- `fp_rd` out 1 — one-cycle read pulse.
- `fp_addr` out ADDR_W — word address, equal to `io_address[ADDR_W+1:2]`.
- `fp_be` out 4 — latched byte enables.
- `fp_wr_data` out 32 — latched write data.
- `fp_rd_data` in 32 — FPRO read data.
- `err_clr` in 1 — clears `err_unmapped`.
- `err_unmapped` out 1 — sticky unmapped-access flag.

## Operation
- **Hit:** `io_address[31:24] == BRG_BASE[31:24]`.
- **Region index:** `io_address[23 -: log2(NUM_CS)]`. With NUM_CS = 1, `fp_cs[0]` is used for every hit.
- **Start condition:** a transaction starts only in IDLE, on `io_addr_strobe` with `io_read_strobe` or `io_write_strobe` high.
- **Both strobes high:** the access is a write.
- **Latch on start:** address, byte enables, write data, region index and direction are captured on the start edge.
- **States:**
  - IDLE → ACCESS on a hit.
  - IDLE → RESP on a miss, only when unmapped responses are compiled in (see Configuration). Otherwise a miss leaves the bridge in IDLE.
  - ACCESS → RESP for a write.
  - ACCESS → RDWAIT for a read.
  - RDWAIT → RESP after RD_LAT cycles.
  - RESP → IDLE.
- **ACCESS:** `fp_wr` or `fp_rd` is high for exactly this one cycle.
- **RDWAIT:** 4-bit counter loaded with RD_LAT−1 on entry. `fp_rd_data` is registered into `io_read_data` on the edge where the counter reads 0.
- **Bus hold:** `fp_cs`, `fp_addr`, `fp_be` and `fp_wr_data` hold from ACCESS through the last RDWAIT cycle. They return to 0 in RESP and IDLE.
- **RESP:** `io_ready` = 1 for one cycle.
- **`io_read_data`:** holds the last read result until the next read completes. Writes do not change it.
- **Strobes while busy** (not in IDLE): ignored, with no queueing.

## Timing
- Start edge = end of cycle 0.
- **Write:** ACCESS (`fp_wr`) in cycle 1; `io_ready` in cycle 2.
- **Read:**
  - `fp_rd` in cycle 1.
  - `fp_rd_data` sampled at the end of cycle 1 + RD_LAT.
  - `io_ready` and the new `io_read_data` valid in cycle 2 + RD_LAT.
  - Default RD_LAT = 1 gives `io_ready` in cycle 3.
- **Back-to-back:** the next start is accepted in the cycle after RESP, i.e. in IDLE.
- **Reset values:** every output = 0 (`io_read_data`, `io_ready`, `fp_cs`, `fp_wr`, `fp_rd`, `fp_addr`, `fp_be`, `fp_wr_data`, `err_unmapped`); state = IDLE; counter = 0.
- **Reset mid-transaction:** the transaction is aborted immediately and no `io_ready` is issued after release.
- **`err_clr` and an unmapped hit in the same cycle:** set wins.

## Configuration
- `FPRO_BRIDGE_UNMAPPED_RESP_EN`
- **Defined:**
  - A started miss goes IDLE → RESP, so `io_ready` arrives in cycle 1.
  - No FPRO strobe or chip-select is asserted.
  - A read miss returns `io_read_data` = 0.
  - `err_unmapped` is set, stays high until `err_clr`, and is cleared on the edge after `err_clr`.
- **Undefined:**
  - Misses are ignored: no `io_ready` and no state change.
  - `err_unmapped` is tied to 0 and `err_clr` is unused.

## Test plan
- **Write hit:** `io_address` = 0xC000_0010, write data 0xA5A5_1234, be = 4'b0011 → cycle 1: `fp_wr` = 1, `fp_cs` = 2'b01, `fp_addr` = 4, `fp_be` = 3, `fp_wr_data` = 0xA5A5_1234; cycle 2: `io_ready` = 1.
- **Read hit, RD_LAT = 3:** video region `io_address` = 0xC080_0008, `fp_rd_data` = 0x1357_9BDF presented in cycle 4 → `fp_cs` = 2'b10 and `fp_addr` = 2 held in cycles 1–4; `fp_rd` high only in cycle 1; `io_ready` and `io_read_data` = 0x1357_9BDF in cycle 5.
- **Busy and simultaneous strobes:** second `io_addr_strobe` in cycle 1 of a write → ignored, exactly one `fp_wr` and one `io_ready`. Read and write strobes together in IDLE → write performed.
- **Miss:** `io_address` = 0x4000_0000 read.
  - With the macro defined → `io_ready` in cycle 1, `io_read_data` = 0, `err_unmapped` = 1; `err_clr` pulse → 0 on the next edge.
  - Without the macro → no response and no FPRO activity.
- **Reset during RDWAIT (RD_LAT = 4):** `reset` asserted in cycle 2 → all outputs 0 immediately; no `io_ready` after release; a new write is accepted normally.
